// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-FF synchroniser, consecutive-cycle debounce counter,
// registered press/release strobes and a one-shot long-press strobe.
module btn_debounce #(
    parameter int DEBOUNCE   = 1000000,
    parameter int LONG       = 100000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(LONG + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic          s1_q, s2_q, s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    assign s = s2_q ^ ACTIVE_LOW;

    always_comb begin
        cnt_d     = '0;
        pressed_d = pressed_q;
        hold_d    = '0;
        long_d    = 1'b0;
        // Any cycle where the input agrees with the state restarts the count.
        if (s != pressed_q) begin
            if (cnt_q == CNT_LAST) pressed_d = ~pressed_q;
            else                   cnt_d     = cnt_q + CNT_ONE;
        end
        press_d   = pressed_d & ~pressed_q;
        release_d = ~pressed_d & pressed_q;
        // Hold time only accrues across edges where the level stays pressed.
        if (pressed_q && pressed_d) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
            long_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            s1_q      <= ACTIVE_LOW;
            s2_q      <= ACTIVE_LOW;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign pressed_o    = pressed_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
endmodule
